// File: rtl/dwt_dma_wr_pkg.sv
// AXI4 encodings shared by the DWT read and write DMA engines.
package dwt_dma_wr_pkg;

  typedef enum logic [1:0] {
    Fixed = 2'b00,
    Incr  = 2'b01,
    Wrap  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  localparam logic [3:0] NormalNonCachBuff = 4'b0011;

  localparam logic [2:0] Size1B   = 3'd0;
  localparam logic [2:0] Size2B   = 3'd1;
  localparam logic [2:0] Size4B   = 3'd2;
  localparam logic [2:0] Size8B   = 3'd3;
  localparam logic [2:0] Size16B  = 3'd4;
  localparam logic [2:0] Size32B  = 3'd5;
  localparam logic [2:0] Size64B  = 3'd6;
  localparam logic [2:0] Size128B = 3'd7;

  // AxSIZE for a full-width beat of the given byte count (power of two).
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    logic [2:0] s;
    s = Size1B;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/dwt_dma_wr.sv
// AXI4 write-master DMA: streams coefficients from AXI-Stream into memory as INCR bursts.
module dwt_dma_wr
  import dwt_dma_wr_pkg::*;
#(
  parameter int unsigned DMA_DATA_WIDTH_DST   = 64,
  parameter int unsigned DMA_AXI_PROTOCOL_DST = 0,
  parameter int unsigned DMA_AXI_ADDR_WIDTH   = 32,
  parameter int unsigned C_M_AXI_ID_WIDTH     = 1,
  parameter int unsigned MAX_BURST            = 16
) (
  input  logic                                m_axi_aclk,
  input  logic                                m_axi_aresetn,
  input  logic                                start,
  input  logic [DMA_AXI_ADDR_WIDTH-1:0]       cfg_addr,
  input  logic [31:0]                         cfg_beats,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  input  logic [DMA_DATA_WIDTH_DST-1:0]       s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic [C_M_AXI_ID_WIDTH-1:0]         m_dst_axi_awid,
  output logic [DMA_AXI_ADDR_WIDTH-1:0]       m_dst_axi_awaddr,
  output logic [7-4*DMA_AXI_PROTOCOL_DST:0]   m_dst_axi_awlen,
  output logic [2:0]                          m_dst_axi_awsize,
  output logic [1:0]                          m_dst_axi_awburst,
  output logic [3:0]                          m_dst_axi_awcache,
  output logic [2:0]                          m_dst_axi_awprot,
  output logic                                m_dst_axi_awvalid,
  input  logic                                m_dst_axi_awready,
  output logic [DMA_DATA_WIDTH_DST-1:0]       m_dst_axi_wdata,
  output logic [DMA_DATA_WIDTH_DST/8-1:0]     m_dst_axi_wstrb,
  output logic                                m_dst_axi_wlast,
  output logic                                m_dst_axi_wvalid,
  input  logic                                m_dst_axi_wready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]         m_dst_axi_bid,
  input  logic [1:0]                          m_dst_axi_bresp,
  input  logic                                m_dst_axi_bvalid,
  output logic                                m_dst_axi_bready
);

  localparam int unsigned BYTES = DMA_DATA_WIDTH_DST / 8;
  localparam int unsigned LEN_W = 8 - 4 * DMA_AXI_PROTOCOL_DST;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t                          state, state_nxt;
  logic                            start_q;
  logic                            trig;
  logic [DMA_AXI_ADDR_WIDTH-1:0]   addr;
  logic [31:0]                     remaining;
  logic [31:0]                     burst_len;
  logic [8:0]                      cur_len;
  logic [7:0]                      beat_cnt;
  logic                            aw_hs, w_hs, b_hs;
  logic                            unused_ok;

  assign trig      = start & ~start_q;
  assign burst_len = (remaining > 32'(MAX_BURST)) ? 32'(MAX_BURST) : remaining;

  assign aw_hs = (state == ADDR) & m_dst_axi_awready;
  assign w_hs  = (state == DATA) & s_axis_tvalid & m_dst_axi_wready;
  assign b_hs  = (state == RESP) & m_dst_axi_bvalid;

  assign m_dst_axi_awid    = '0;
  assign m_dst_axi_awaddr  = addr;
  assign m_dst_axi_awlen   = LEN_W'(burst_len - 32'd1);
  assign m_dst_axi_awsize  = axi_size(BYTES);
  assign m_dst_axi_awburst = Incr;
  assign m_dst_axi_awcache = NormalNonCachBuff;
  assign m_dst_axi_awprot  = '0;
  assign m_dst_axi_wdata   = s_axis_tdata;
  assign m_dst_axi_wstrb   = '1;
  assign unused_ok         = ^m_dst_axi_bid;

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      err       <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      cur_len   <= '0;
      beat_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      if (state == IDLE && trig) begin
        addr      <= cfg_addr;
        remaining <= cfg_beats;
        if (cfg_beats != '0) err <= 1'b0;
      end
      // Remaining is charged at AW time so RESP can decide DONE vs ADDR directly.
      if (aw_hs) begin
        remaining <= remaining - burst_len;
        cur_len   <= 9'(burst_len);
        beat_cnt  <= 8'(burst_len - 32'd1);
      end
      if (w_hs) beat_cnt <= beat_cnt - 8'd1;
      if (b_hs) begin
        if (m_dst_axi_bresp != OKAY) err <= 1'b1;
        addr <= addr + DMA_AXI_ADDR_WIDTH'(32'(cur_len) * BYTES);
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    busy              = 1'b0;
    done              = 1'b0;
    m_dst_axi_awvalid = 1'b0;
    m_dst_axi_wvalid  = 1'b0;
    m_dst_axi_wlast   = 1'b0;
    m_dst_axi_bready  = 1'b0;
    s_axis_tready     = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig) state_nxt = (cfg_beats == '0) ? DONE : ADDR;
      end
      ADDR: begin
        busy              = 1'b1;
        m_dst_axi_awvalid = 1'b1;
        if (m_dst_axi_awready) state_nxt = DATA;
      end
      DATA: begin
        busy             = 1'b1;
        m_dst_axi_wvalid = s_axis_tvalid;
        s_axis_tready    = m_dst_axi_wready;
        m_dst_axi_wlast  = (beat_cnt == '0);
        if (w_hs && beat_cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        busy             = 1'b1;
        m_dst_axi_bready = 1'b1;
        if (m_dst_axi_bvalid) state_nxt = (remaining == '0) ? DONE : ADDR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
